// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//   Load/store unit initiator for the unified data-memory port (data RAM plus
//   LED, millis and micros peripherals). Takes one request at a time from the
//   execute stage, rejects misaligned or illegal-funct3 requests, drives the
//   memory port for exactly one access cycle, captures load data one cycle
//   later and returns a single-cycle response.
//
// Ports
//   clk, reset            system clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake from execute stage
//   req_write             1 = store, 0 = load
//   req_funct3            RV32I funct3 of the access
//   req_address           effective byte address
//   req_store_data        right-aligned store data
//   rsp_valid             one-cycle response pulse
//   rsp_data              load result, 0 for stores, faulting address on error
//   rsp_error             misaligned address or illegal funct3
//   funct3, dmem_wren,
//   dmem_address,
//   dmem_data_in          memory-port outputs, all registered
//   dmem_data_out         memory read data, valid one cycle after address sample
//   load_count,
//   store_count,
//   error_count           wrapping completion counters
//
// state   | meaning
// IDLE    | ready for a request; port outputs hold last values, wren low
// ACCESS  | memory samples address/funct3/wren at the end of this cycle
// CAPTURE | load only: read data valid, latched into rsp_data
// RESP    | rsp_valid high for one cycle, counter update, back to IDLE

module lsu_mem_port #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [2:0]             req_funct3,
   input  logic [31:0]            req_address,
   input  logic [31:0]            req_store_data,
   output logic                   rsp_valid,
   output logic [31:0]            rsp_data,
   output logic                   rsp_error,
   output logic [2:0]             funct3,
   output logic                   dmem_wren,
   output logic [31:0]            dmem_address,
   output logic [31:0]            dmem_data_in,
   input  logic [31:0]            dmem_data_out,
   output logic [COUNT_WIDTH-1:0] load_count,
   output logic [COUNT_WIDTH-1:0] store_count,
   output logic [COUNT_WIDTH-1:0] error_count
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

   state_e                 state_q;
   logic                   req_ready_q;
   logic                   rsp_valid_q;
   logic                   rsp_error_q;
   logic [31:0]            rsp_data_q;
   logic [2:0]             funct3_q;
   logic                   dmem_wren_q;
   logic                   write_q;
   logic [31:0]            dmem_address_q;
   logic [31:0]            dmem_data_in_q;
   logic [COUNT_WIDTH-1:0] load_count_q;
   logic [COUNT_WIDTH-1:0] store_count_q;
   logic [COUNT_WIDTH-1:0] error_count_q;

   logic align_ok;
   logic funct3_ok;
   logic req_legal;

   always_comb begin
      align_ok = 1'b1;
      if (req_funct3[1:0] == 2'b10) begin
         align_ok = (req_address[1:0] == 2'b00);
      end else if (req_funct3[1:0] == 2'b01) begin
         align_ok = ~req_address[0];
      end
      if (req_write) begin
         funct3_ok = (req_funct3 inside {3'd0, 3'd1, 3'd2});
      end else begin
         funct3_ok = (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      req_legal = align_ok & funct3_ok;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         req_ready_q    <= 1'b1;
         rsp_valid_q    <= 1'b0;
         rsp_error_q    <= 1'b0;
         rsp_data_q     <= '0;
         funct3_q       <= '0;
         dmem_wren_q    <= 1'b0;
         write_q        <= 1'b0;
         dmem_address_q <= '0;
         dmem_data_in_q <= '0;
         load_count_q   <= '0;
         store_count_q  <= '0;
         error_count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  if (req_legal) begin
                     dmem_address_q <= req_address;
                     funct3_q       <= req_funct3;
                     dmem_data_in_q <= req_store_data;
                     write_q        <= req_write;
                     dmem_wren_q    <= req_write;
                     state_q        <= ACCESS;
                  end else begin
                     // rejected requests never touch the memory port
                     rsp_data_q  <= req_address;
                     rsp_error_q <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end
               end
            end
            ACCESS: begin
               dmem_wren_q <= 1'b0;
               if (write_q) begin
                  rsp_data_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               rsp_data_q  <= dmem_data_out;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               // write_q is stale on the error path, so test the error first
               if (rsp_error_q) begin
                  error_count_q <= error_count_q + 1'b1;
               end else if (write_q) begin
                  store_count_q <= store_count_q + 1'b1;
               end else begin
                  load_count_q <= load_count_q + 1'b1;
               end
               rsp_valid_q <= 1'b0;
               rsp_error_q <= 1'b0;
               rsp_data_q  <= '0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_error    = rsp_error_q;
   assign rsp_data     = rsp_data_q;
   assign funct3       = funct3_q;
   assign dmem_wren    = dmem_wren_q;
   assign dmem_address = dmem_address_q;
   assign dmem_data_in = dmem_data_in_q;
   assign load_count   = load_count_q;
   assign store_count  = store_count_q;
   assign error_count  = error_count_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [2:0]    req_funct3 = '0;
   logic [31:0]   req_address = '0;
   logic [31:0]   req_store_data = '0;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic          rsp_error;
   logic [2:0]    funct3;
   logic          dmem_wren;
   logic [31:0]   dmem_address;
   logic [31:0]   dmem_data_in;
   logic [31:0]   dmem_data_out = '0;
   logic [CW-1:0] load_count;
   logic [CW-1:0] store_count;
   logic [CW-1:0] error_count;

   lsu_mem_port #(.COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
      .funct3(funct3), .dmem_wren(dmem_wren), .dmem_address(dmem_address),
      .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
      .load_count(load_count), .store_count(store_count), .error_count(error_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic        err;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   int          acc_q[$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          nrsp = 0;
   int          wren_cycles = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [2:0]  wr_f3 = '0;
   logic [31:0] mem [256];
   exp_t        mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
      logic [31:0] s;
      s = w >> {a, 3'b000};
      case (f3)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd2:    return s;
         3'd4:    return {24'h0, s[7:0]};
         3'd5:    return {16'h0, s[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] wr_model(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] m;
      case (f3[1:0])
         2'b00:   m = 32'h0000_00FF;
         2'b01:   m = 32'h0000_FFFF;
         default: m = 32'hFFFF_FFFF;
      endcase
      return (w & ~(m << {a, 3'b000})) | ((d & m) << {a, 3'b000});
   endfunction

   // memory: samples the port at every edge, read data one cycle later
   initial for (int i = 0; i < 256; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (dmem_wren)
         mem[dmem_address[9:2]] <= wr_model(mem[dmem_address[9:2]], dmem_address[1:0],
                                            funct3, dmem_data_in);
      dmem_data_out <= rd_model(mem[dmem_address[9:2]], dmem_address[1:0], funct3);
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset && req_valid && req_ready) acc_q.push_back(cyc);
   end

   always @(negedge clk) begin
      if (dmem_wren) begin
         wren_cycles++;
         wr_addr = dmem_address;
         wr_data = dmem_data_in;
         wr_f3   = funct3;
      end
      if (rsp_valid) begin
         nrsp++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: actual rsp_data %h, required no response", rsp_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_error", 32'(rsp_error), 32'(mon_e.err));
            check("rsp_data", rsp_data, mon_e.data);
            if (acc_q.size() == 0) check("accept_seen", 32'd0, 32'd1);
            else check("latency", 32'(cyc - acc_q.pop_front()), 32'(mon_e.lat));
         end
      end
   end

   task automatic set_req(input vec_t v);
      req_write      = v.wr;
      req_funct3     = v.f3;
      req_address    = v.addr;
      req_store_data = v.sdata;
   endtask

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.err  = v.err;
      e.data = v.data;
      e.lat  = v.err ? 1 : (v.wr ? 2 : 3);
      exp_q.push_back(e);
   endtask

   // call #1 after a rising edge; returns #1 after the edge that re-enters IDLE
   task automatic issue(input vec_t v);
      int n;
      set_req(v);
      req_valid = 1'b1;
      push_exp(v);
      wren_cycles = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 20);
      check("accept_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rsp_pending", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      check("wren_cycles", 32'(wren_cycles), (v.wr && !v.err) ? 32'd1 : 32'd0);
      if (v.wr && !v.err) begin
         check("wr_addr", wr_addr, v.addr);
         check("wr_funct3", 32'(wr_f3), 32'(v.f3));
         check("wr_data", wr_data, v.sdata);
      end
      if (!v.err) check("addr_held", dmem_address, v.addr);
   endtask

   vec_t tbl[17];
   vec_t bb[4];
   vec_t v;
   int   nload = 0, nstore = 0, nerr = 0, idx, rsp0;

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         1'b0, 32'hFFFF_FFDE};
      tbl[2]  = '{1'b0, 3'd5, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_DEAD};
      tbl[3]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
      tbl[4]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,         1'b1, 32'h0000_0102};
      tbl[5]  = '{1'b1, 3'd1, 32'h0000_0101, 32'h5555,      1'b1, 32'h0000_0101};
      tbl[6]  = '{1'b0, 3'd3, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0100};
      tbl[7]  = '{1'b1, 3'd0, 32'hFFFF_FFFE, 32'h0000_0080, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 3'd4, 32'hFFFF_FFFE, 32'h0,         1'b0, 32'h0000_0080};
      tbl[9]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,         1'b0, 32'hFFFF_DEAD};
      tbl[10] = '{1'b1, 3'd1, 32'h0000_0104, 32'hABCD_1234, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 3'd2, 32'h0000_0104, 32'h0,         1'b0, 32'h0000_1234};
      tbl[12] = '{1'b1, 3'd4, 32'h0000_0108, 32'h1111,      1'b1, 32'h0000_0108};
      tbl[13] = '{1'b0, 3'd6, 32'h0000_010C, 32'h0,         1'b1, 32'h0000_010C};
      tbl[14] = '{1'b0, 3'd1, 32'h0000_0105, 32'h0,         1'b1, 32'h0000_0105};
      tbl[15] = '{1'b0, 3'd4, 32'h0000_0101, 32'h0,         1'b0, 32'h0000_00BE};
      tbl[16] = '{1'b0, 3'd0, 32'hFFFF_FFF4, 32'h0,         1'b0, 32'h0};
      bb[0]   = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
      bb[1]   = '{1'b0, 3'd5, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_DEAD};
      bb[2]   = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,         1'b0, 32'h0000_00DE};
      bb[3]   = '{1'b0, 3'd0, 32'h0000_0101, 32'h0,         1'b0, 32'hFFFF_FFBE};

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_dmem_wren", 32'(dmem_wren), 32'd0);
      check("rst_dmem_address", dmem_address, 32'h0);
      check("rst_counts", 32'({load_count, store_count, error_count}), 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         issue(tbl[i]);
         if (tbl[i].err) nerr++;
         else if (tbl[i].wr) nstore++;
         else nload++;
         if (i == 0) check("store_count_first", 32'(store_count), 32'd1);
      end
      check("load_count", 32'(load_count), 32'(nload % 16));
      check("store_count", 32'(store_count), 32'(nstore % 16));
      check("error_count", 32'(error_count), 32'(nerr % 16));

      // back-to-back loads with req_valid held high
      rsp0 = nrsp;
      idx  = 0;
      set_req(bb[0]);
      req_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check("ready_pattern", 32'(req_ready), (k % 4 == 0) ? 32'd1 : 32'd0);
         if (req_ready && idx < 4) begin
            push_exp(bb[idx]);
            @(posedge clk);
            #1;
            idx++;
            if (idx < 4) set_req(bb[idx]);
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("bb_responses", 32'(nrsp - rsp0), 32'd4);
      check("bb_pending", 32'(exp_q.size()), 32'd0);
      nload += 4;
      check("load_count_bb", 32'(load_count), 32'(nload % 16));
      @(posedge clk);
      #1;

      // error counter wraps through all-ones
      v = '{1'b0, 3'd3, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0040};
      for (int i = 0; i < 17; i++) begin
         issue(v);
         nerr++;
      end
      check("error_count_wrap", 32'(error_count), 32'(nerr % 16));

      // reset in the middle of a store access
      v = '{1'b1, 3'd2, 32'h0000_0200, 32'h1234_5678, 1'b0, 32'h0};
      set_req(v);
      req_valid = 1'b1;
      @(negedge clk);
      check("abort_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("abort_wren_access", 32'(dmem_wren), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_wren", 32'(dmem_wren), 32'd0);
      check("abort_ready_rst", 32'(req_ready), 32'd1);
      check("abort_rsp", 32'({rsp_valid, rsp_error}), 32'd0);
      check("abort_rsp_data", rsp_data, 32'h0);
      check("abort_address", dmem_address, 32'h0);
      check("abort_data_in", dmem_data_in, 32'h0);
      check("abort_funct3", 32'(funct3), 32'd0);
      check("abort_counts", 32'({load_count, store_count, error_count}), 32'h0);
      acc_q.delete();
      @(negedge clk);
      reset = 1'b1;
      rsp0 = nrsp;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_ready", 32'(req_ready), 32'd1);
      end
      check("post_rst_no_rsp", 32'(nrsp - rsp0), 32'd0);
      @(posedge clk);
      #1;
      v = '{1'b0, 3'd2, 32'h0000_0200, 32'h0, 1'b0, 32'h0};
      issue(v);
      check("post_rst_load_count", 32'(load_count), 32'd1);
      check("post_rst_store_count", 32'(store_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Processor-side load/store unit. It is the initiator for the unified data-memory port, which serves data RAM plus the LED, millis and micros peripherals.
- It accepts one load/store request at a time from the execute stage through a valid/ready handshake.
- It checks alignment and funct3 legality, then drives the memory port for exactly one access cycle.
- It captures the read data one cycle after the access and returns a single-cycle response with data or an error flag.

Parameters:
COUNT_WIDTH, 16, width of the completed-load, completed-store and error counters (wrap mod 2^COUNT_WIDTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present from execute stage
req_ready  output  1  LSU can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_address  input  32  effective byte address (rs1 + imm)
req_store_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle response pulse
rsp_data  output  32  load result; 0 for stores; faulting address on error
rsp_error  output  1  qualifies rsp_valid: misaligned address or illegal funct3
funct3  output  3  to memory port
dmem_wren  output  1  to memory port, write enable
dmem_address  output  32  to memory port
dmem_data_in  output  32  to memory port, store data passed unshifted
dmem_data_out  input  32  from memory port, already sign/zero-extended, valid one cycle after address is sampled
load_count  output  COUNT_WIDTH  completed non-error loads
store_count  output  COUNT_WIDTH  completed non-error stores
error_count  output  COUNT_WIDTH  error responses

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All outputs 0 except req_ready=1.
  - dmem_wren forced 0 immediately.
  - Counters cleared.
- FSM states: IDLE, ACCESS, CAPTURE, RESP. All memory-port outputs come straight from registers, with no combinational path from req_*.
- IDLE:
  - req_ready=1; a request is accepted on a rising edge with req_valid=1.
  - Legality check at accept:
    - funct3[1:0]=2'b10 (word) requires address[1:0]=0.
    - funct3[1:0]=2'b01 (half) requires address[0]=0.
    - Loads: funct3 in {0,1,2,4,5} is legal.
    - Stores: funct3 in {0,1,2} is legal.
  - Illegal request: latch rsp_data=req_address, rsp_error=1, go to RESP. The memory port is untouched and dmem_wren stays 0.
  - Legal request: register dmem_address, funct3, dmem_data_in and the write flag, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Port outputs stable; dmem_wren=1 only for stores.
  - The memory samples address/funct3/write at the end of this cycle.
  - Next state: CAPTURE for loads, RESP for stores. dmem_wren returns to 0 on leaving.
- CAPTURE (loads only):
  - Port outputs held unchanged.
  - rsp_data <= dmem_data_out at the end of the cycle; go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; no backpressure, the consumer must take it.
  - rsp_data=0 for stores.
  - The matching counter increments on this cycle's edge: load_count, store_count, or error_count if rsp_error.
  - Go to IDLE.
- rsp_valid, rsp_error and rsp_data are 0 outside RESP.
- Port outputs other than dmem_wren keep their last values in IDLE.
- req_ready=0 in ACCESS, CAPTURE and RESP. A request held valid is accepted on the first IDLE edge; there is no lost or duplicate request.
- Latency from accept edge to rsp_valid: load 3 cycles, store 2 cycles, error 1 cycle. Back-to-back throughput: one load per 4 cycles, one store per 3 cycles.
- Peripheral addresses (0xFFFFFFF4/F8/FC) and out-of-range addresses are passed through unchanged. Range decoding belongs to the memory. Alignment rules still apply.
- Counters wrap from all-ones to 0.
- Reset asserted mid-ACCESS aborts the operation: dmem_wren drops asynchronously, no response is issued, and counters are cleared.

Test Plan:
- Store sw 0xDEADBEEF at 0x100: dmem_wren high for exactly 1 cycle with address 0x100 and funct3=2. rsp_valid 2 cycles after accept with rsp_data=0. store_count=1.
- Loads after the 0xDEADBEEF store:
  - lb 0x103: rsp_data=0xFFFFFFDE, rsp_valid 3 cycles after accept.
  - lhu 0x102: rsp_data=0x0000DEAD.
  - lw 0x100: rsp_data=0xDEADBEEF.
  - load_count=3.
- lw 0x102, then sh 0x101, then load funct3=3 at 0x100: each gives rsp_valid with rsp_error=1 one cycle after accept, rsp_data equal to the request address (0x102, 0x101, 0x100), dmem_wren never asserted. error_count=3.
- req_valid held high for 4 consecutive loads: req_ready pattern 1,0,0,0 repeating. Exactly 4 responses, in order, with no duplicates.
- sb 0x80 to 0xFFFFFFFE: dmem_address=0xFFFFFFFE, dmem_data_in[7:0]=0x80, funct3=0, single-cycle wren. A following lbu 0xFFFFFFFE returns 0x00000080.
- Reset pulled low during ACCESS of a store: dmem_wren=0 within the same cycle, and all outputs and counters are 0. After release, req_ready=1 and no stray rsp_valid appears.
